// File: rtl/credit_packet_sender_pkg.sv
// Shared types and field layout for the credit-based packet sender.
package credit_packet_sender_pkg;

  localparam int unsigned TYPE_W = 2;
  localparam int unsigned ID_W   = 10;

  // Field positions, counted down from the flit MSB (DW-1).
  localparam int unsigned SID_MSB_OFS = TYPE_W;
  localparam int unsigned DST_MSB_OFS = TYPE_W + ID_W;

  typedef enum logic [TYPE_W-1:0] {
    FT_BODY = 2'b00,
    FT_HEAD = 2'b01,
    FT_TAIL = 2'b10
  } flit_type_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BODY,
    ST_TAIL
  } state_t;

endpackage

// File: rtl/credit_packet_sender_credit_counter.sv
// Saturating credit counter: whole-packet reservation on start, +1 per credit return.
module credit_counter #(
  parameter int unsigned CREDITS = 16,
  parameter int unsigned PKT_LEN = 8,
  parameter int unsigned CW      = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          credit_upd,
  output logic [CW-1:0] credit_cnt,
  output logic          credit_err
);

  localparam logic [CW:0] PKT_W = (CW + 1)'(PKT_LEN);
  localparam logic [CW:0] MAX_W = (CW + 1)'(CREDITS);

  logic [CW:0] sum;

  // Start and return in the same cycle are both applied; start is only issued with enough credits.
  always_comb begin
    sum = {1'b0, credit_cnt} - (start ? PKT_W : '0) + {{CW{1'b0}}, credit_upd};
  end

  // Counter register with saturation and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_cnt <= CW'(CREDITS);
      credit_err <= 1'b0;
    end else if (sum > MAX_W) begin
      credit_cnt <= CW'(CREDITS);
      credit_err <= 1'b1;
    end else begin
      credit_cnt <= sum[CW-1:0];
    end
  end

endmodule

// File: rtl/credit_packet_sender.sv
// Packetizes a PE payload stream into HEAD/BODY/TAIL flits, gated by downstream credits.
module credit_packet_sender
  import credit_packet_sender_pkg::*;
#(
  parameter int unsigned     DW      = 32,
  parameter int unsigned     PKT_LEN = 8,
  parameter int unsigned     CREDITS = 16,
  parameter logic [ID_W-1:0] SID     = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_i_pe,
  input  logic [DW-3:0]                data_i_pe,
  input  logic [ID_W-1:0]              dst_i_pe,
  output logic                         ready_o_pe,
  output logic                         valid_o_nw,
  output logic [DW-1:0]                data_o_nw,
  input  logic                         ready_i_nw,
  input  logic                         credit_upd,
  output logic [$clog2(CREDITS+1)-1:0] credit_cnt,
  output logic [15:0]                  pkt_cnt,
  output logic                         credit_err
);

  localparam int unsigned CW = $clog2(CREDITS + 1);
  localparam int unsigned BW = $clog2(PKT_LEN);

  if (CREDITS < PKT_LEN) begin : g_chk_credits
    $error("credit_packet_sender: CREDITS must be >= PKT_LEN");
  end
  if (PKT_LEN < 3) begin : g_chk_len
    $error("credit_packet_sender: PKT_LEN must be >= 3");
  end

  state_t        state, state_next;
  logic [BW-1:0] body_cnt;
  logic          slot_free;
  logic          start, pe_hs, tail_load, last_body;
  logic [DW-1:0] load_flit;

  assign slot_free = ~valid_o_nw | ready_i_nw;
  assign last_body = (body_cnt == BW'(PKT_LEN - 3));

  credit_counter #(
    .CREDITS (CREDITS),
    .PKT_LEN (PKT_LEN),
    .CW      (CW)
  ) u_credit (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .credit_upd (credit_upd),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start) state_next = ST_BODY;
      ST_BODY: if (pe_hs && last_body) state_next = ST_TAIL;
      ST_TAIL: if (tail_load) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Per-state handshakes and the flit to load into the output register.
  always_comb begin
    ready_o_pe = 1'b0;
    start      = 1'b0;
    pe_hs      = 1'b0;
    tail_load  = 1'b0;
    load_flit  = '0;
    unique case (state)
      ST_IDLE: begin
        start = valid_i_pe && (credit_cnt >= CW'(PKT_LEN)) && slot_free;
        load_flit[DW-1 -: TYPE_W]               = FT_HEAD;
        load_flit[DW-1-SID_MSB_OFS -: ID_W]     = SID;
        load_flit[DW-1-DST_MSB_OFS -: ID_W]     = dst_i_pe;
      end
      ST_BODY: begin
        ready_o_pe = slot_free;
        pe_hs      = valid_i_pe && slot_free;
        load_flit  = {FT_BODY, data_i_pe};
      end
      ST_TAIL: begin
        tail_load              = slot_free;
        load_flit[DW-1 -: TYPE_W] = FT_TAIL;
        load_flit[15:0]        = pkt_cnt;
      end
      default: ;
    endcase
  end

  // Output register: load when the slot is free, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o_nw <= 1'b0;
      data_o_nw  <= '0;
    end else if (slot_free) begin
      valid_o_nw <= start | pe_hs | tail_load;
      if (start | pe_hs | tail_load) data_o_nw <= load_flit;
    end
  end

  // Body word counter and completed-packet counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      body_cnt <= '0;
      pkt_cnt  <= '0;
    end else begin
      if (start)          body_cnt <= '0;
      else if (pe_hs)     body_cnt <= body_cnt + BW'(1);
      if (tail_load)      pkt_cnt  <= pkt_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_credit_packet_sender.sv
// Directed scoreboard bench for credit_packet_sender (defaults, SID=3).
module tb_credit_packet_sender;
  import credit_packet_sender_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i_pe;
  logic [29:0] data_i_pe;
  logic [9:0]  dst_i_pe;
  logic        ready_o_pe;
  logic        valid_o_nw;
  logic [31:0] data_o_nw;
  logic        ready_i_nw;
  logic        credit_upd;
  logic [4:0]  credit_cnt;
  logic [15:0] pkt_cnt;
  logic        credit_err;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  int pay_next = 1;
  int pay_limit = 0;
  int seq_model = 0;
  int flits_seen = 0;
  bit held_v = 0;
  logic [31:0] held_d = '0;

  credit_packet_sender #(
    .DW      (32),
    .PKT_LEN (8),
    .CREDITS (16),
    .SID     (10'd3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i_pe (valid_i_pe),
    .data_i_pe  (data_i_pe),
    .dst_i_pe   (dst_i_pe),
    .ready_o_pe (ready_o_pe),
    .valid_o_nw (valid_o_nw),
    .data_o_nw  (data_o_nw),
    .ready_i_nw (ready_i_nw),
    .credit_upd (credit_upd),
    .credit_cnt (credit_cnt),
    .pkt_cnt    (pkt_cnt),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endfunction

  function automatic logic [31:0] head_flit(logic [9:0] dst);
    return {FT_HEAD, 10'd3, dst, 10'd0};
  endfunction

  // Queue a whole packet's expected flits and make the source offer its payload.
  task automatic start_pkt(logic [9:0] dst);
    int base;
    base = pay_limit + 1;
    exp_q.push_back(head_flit(dst));
    for (int i = 0; i < 6; i++) exp_q.push_back({FT_BODY, 30'(base + i)});
    exp_q.push_back({FT_TAIL, 14'd0, 16'(seq_model)});
    seq_model++;
    pay_limit = base + 5;
    dst_i_pe = dst;
    data_i_pe = 30'(pay_next);
    valid_i_pe = (pay_next <= pay_limit);
  endtask

  // One clock: observe at negedge, advance the source, settle #1 past posedge.
  task automatic tick();
    bit adv;
    adv = 0;
    @(negedge clk);
    if (!rst) begin
      if (held_v) begin
        check("hold_valid", 32'(valid_o_nw), 32'd1);
        check("hold_data", data_o_nw, held_d);
      end
      if (valid_o_nw && !ready_i_nw) begin
        check("stall_ready_pe", 32'(ready_o_pe), 32'd0);
        held_v = 1;
        held_d = data_o_nw;
      end else begin
        held_v = 0;
      end
      if (valid_o_nw && ready_i_nw) begin
        if (exp_q.size() == 0) check("flit_unexpected", 32'(valid_o_nw), 32'd0);
        else check("flit", data_o_nw, exp_q.pop_front());
        flits_seen++;
      end
      if (valid_i_pe && ready_o_pe) adv = 1;
    end else begin
      held_v = 0;
    end
    @(posedge clk);
    #1;
    if (adv) pay_next++;
    data_i_pe = 30'(pay_next);
    valid_i_pe = (pay_next <= pay_limit);
  endtask

  task automatic drain(string name, int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(exp_q.size() == 0 && !valid_o_nw) && n < max);
    check(name, 32'(exp_q.size() == 0 && !valid_o_nw), 32'd1);
  endtask

  initial begin
    int n;
    int f0;
    rst = 1; valid_i_pe = 0; data_i_pe = '0; dst_i_pe = '0;
    ready_i_nw = 1; credit_upd = 0;

    // Reset
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("rst_valid", 32'(valid_o_nw), 32'd0);
    check("rst_ready", 32'(ready_o_pe), 32'd0);
    check("rst_credit", 32'(credit_cnt), 32'd16);
    check("rst_pkt", 32'(pkt_cnt), 32'd0);
    check("rst_err", 32'(credit_err), 32'd0);

    // Single packet, payload 1..6
    start_pkt(10'd5);
    tick();
    check("p1_head", data_o_nw, head_flit(10'd5));
    check("p1_credit", 32'(credit_cnt), 32'd8);
    drain("p1_drain", 40, n);
    check("p1_cycles", 32'(n + 1), 32'd9);
    check("p1_pkt", 32'(pkt_cnt), 32'd1);

    // Credit stall: two packets back to back, third waits
    start_pkt(10'd7);
    start_pkt(10'd7);
    repeat (12) tick();
    check("stall_credit", 32'(credit_cnt), 32'd0);
    check("stall_valid", 32'(valid_o_nw), 32'd0);
    check("stall_ready", 32'(ready_o_pe), 32'd0);
    check("stall_pkt", 32'(pkt_cnt), 32'd2);
    check("stall_q", 32'(exp_q.size()), 32'd8);
    credit_upd = 1;
    repeat (8) tick();
    credit_upd = 0;
    check("refill_credit", 32'(credit_cnt), 32'd8);
    check("refill_not_yet", 32'(valid_o_nw), 32'd0);
    tick();
    check("refill_head", data_o_nw, head_flit(10'd7));
    check("refill_credit0", 32'(credit_cnt), 32'd0);
    drain("p3_drain", 40, n);
    check("p3_pkt", 32'(pkt_cnt), 32'd3);
    credit_upd = 1;
    repeat (16) tick();
    credit_upd = 0;
    check("restore_credit", 32'(credit_cnt), 32'd16);
    check("restore_err", 32'(credit_err), 32'd0);

    // Backpressure: ready alternates
    f0 = flits_seen;
    start_pkt(10'd2);
    n = 0;
    do begin
      ready_i_nw = ~ready_i_nw;
      tick();
      n++;
    end while (!(exp_q.size() == 0 && !valid_o_nw) && n < 60);
    ready_i_nw = 1;
    check("bp_drain", 32'(exp_q.size() == 0 && !valid_o_nw), 32'd1);
    check("bp_flits", 32'(flits_seen - f0), 32'd8);
    check("bp_pkt", 32'(pkt_cnt), 32'd4);
    check("bp_credit", 32'(credit_cnt), 32'd8);

    // Start and credit return in the same cycle
    start_pkt(10'd4);
    credit_upd = 1;
    tick();
    credit_upd = 0;
    check("sim_head", data_o_nw, head_flit(10'd4));
    check("sim_credit", 32'(credit_cnt), 32'd1);
    drain("p5_drain", 40, n);
    credit_upd = 1;
    repeat (15) tick();
    credit_upd = 0;
    check("full_credit", 32'(credit_cnt), 32'd16);
    check("full_err", 32'(credit_err), 32'd0);
    credit_upd = 1;
    tick();
    credit_upd = 0;
    check("ovf_credit", 32'(credit_cnt), 32'd16);
    check("ovf_err", 32'(credit_err), 32'd1);
    repeat (3) tick();
    check("ovf_sticky", 32'(credit_err), 32'd1);

    // Mid-packet reset after the third body flit
    start_pkt(10'd6);
    repeat (4) tick();
    check("mid_body3", data_o_nw, {FT_BODY, 30'(pay_limit - 3)});
    rst = 1;
    tick();
    check("mrst_valid", 32'(valid_o_nw), 32'd0);
    check("mrst_credit", 32'(credit_cnt), 32'd16);
    check("mrst_ready", 32'(ready_o_pe), 32'd0);
    check("mrst_pkt", 32'(pkt_cnt), 32'd0);
    check("mrst_err", 32'(credit_err), 32'd0);
    rst = 0;
    exp_q.delete();
    seq_model = 0;
    pay_limit = pay_next - 1;
    start_pkt(10'd9);
    tick();
    check("mrst_head", data_o_nw, head_flit(10'd9));
    drain("p6_drain", 40, n);
    check("p6_pkt", 32'(pkt_cnt), 32'd1);
    check("p6_credit", 32'(credit_cnt), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
